sram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of a `multi_sram` bank between `NUM_REQ` requesters, such as the DMA loader, the compute engine and the writeback unit. Each requester uses a valid/ready handshake. The arbiter drives the bank's `en`/`we`/`addr`/`data_in` slice for one SRAM and routes read data back to the requester that issued the read, with a registered response. One instance sits in front of each shared SRAM in the `multi_sram` array.

---
 rtl/sram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NUM_REQ valid/ready
// requesters. The grant is combinational; read data comes back through a
// two-stage tracking pipeline, so rsp_valid rises two cycles after the read
// is accepted.
// Optional feature: define SRAM_ARB_BURST_LOCK_EN to hold the grant on one
// requester until req_last or MAX_BURST beats.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             sram_en,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_wdata,
    input  logic [DATA_WIDTH-1:0]            sram_rdata,
    output logic                             busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] next_ptr;
    logic          grant_any;
    logic          accept;
    logic          rd_vld;
    logic [IW-1:0] rd_id;

`ifdef SRAM_ARB_BURST_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic          locked;
    logic [IW-1:0] lock_id;
    logic [CW-1:0] beat_cnt;
`else
    // Without burst locking the last-beat marker has no effect.
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Pick the first valid requester at or after rr_ptr (wrapping); a held
    // burst lock overrides the search.
    always_comb begin
        int idx;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx[IW-1:0];
            end
        end
`ifdef SRAM_ARB_BURST_LOCK_EN
        if (locked) begin
            grant_any = 1'b1;
            grant_id  = lock_id;
        end
`endif
    end

    // Ready is forced low while in reset so nothing can be accepted then.
    always_comb begin
        req_ready = '0;
        if (grant_any && rst) req_ready[grant_id] = 1'b1;
    end

    assign accept   = grant_any && rst && req_valid[grant_id];
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Steer the granted requester onto the SRAM port; idle port is all zero.
    always_comb begin
        sram_en    = accept;
        sram_we    = accept && req_we[grant_id];
        sram_addr  = '0;
        sram_wdata = '0;
        if (accept) begin
            sram_addr  = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SRAM_ARB_BURST_LOCK_EN
    // Round-robin pointer and burst lock: a non-last beat opens a lock, which
    // closes on req_last or the MAX_BURST-th beat; rr_ptr moves only on close.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_id  <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (!locked) begin
                if (!req_last[grant_id] && MAX_BURST > 1) begin
                    locked   <= 1'b1;
                    lock_id  <= grant_id;
                    beat_cnt <= CW'(1);
                end else begin
                    rr_ptr <= next_ptr;
                end
            end else if (req_last[grant_id] || beat_cnt == CW'(MAX_BURST - 1)) begin
                locked <= 1'b0;
                rr_ptr <= next_ptr;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
`else
    // Round-robin pointer advances past every accepted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rr_ptr <= '0;
        else if (accept) rr_ptr <= next_ptr;
    end
`endif

    // Read tracking: stage 1 remembers who read, stage 2 returns the data
    // the SRAM presents one cycle after the enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld    <= 1'b0;
            rd_id     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rd_vld    <= accept && !req_we[grant_id];
            rd_id     <= grant_id;
            rsp_valid <= '0;
            if (rd_vld) begin
                rsp_valid[rd_id] <= 1'b1;
                rsp_rdata        <= sram_rdata;
            end
        end
    end

    assign busy = (|req_valid) | rd_vld | (|rsp_valid);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model (search-based grant,
// response scoreboard keyed by due cycle, flat memory array).
module tb_sram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MB = 16;
`ifdef SRAM_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
    logic            sram_en, sram_we, busy;
    logic [AW-1:0]   sram_addr;

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: write commits at the edge, read data one cycle later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        sram_rdata = '0;
    end
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    // Reference model state.
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic [DW-1:0] m_last;
    int            m_rr, m_owner, m_beats, cyc;
    int            n_cmp, n_err;

    int            e_gnt;
    logic [N-1:0]  e_ready, e_rsp_valid;
    logic          e_acc, e_en, e_we, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rsp_rdata;

    function automatic void model_reset();
        q.delete();
        m_last = '0; m_rr = 0; m_owner = -1; m_beats = 0;
    endfunction

    // Expected outputs for the current cycle from model state and inputs.
    function automatic void eval_model();
        bit found;
        e_gnt = -1; e_ready = '0; found = 1'b0;
        if (rst) begin
            if (m_owner >= 0) e_gnt = m_owner;
            else for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (!found && req_valid[j]) begin e_gnt = j; found = 1'b1; end
            end
        end
        if (e_gnt >= 0) e_ready[e_gnt] = 1'b1;
        e_acc   = (e_gnt >= 0) && req_valid[e_gnt];
        e_en    = e_acc;
        e_we    = e_acc && req_we[e_gnt];
        e_addr  = e_acc ? req_addr[e_gnt*AW +: AW] : '0;
        e_wdata = e_acc ? req_wdata[e_gnt*DW +: DW] : '0;
        e_rsp_valid = '0; e_rsp_rdata = m_last;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rsp_valid[q[0].id] = 1'b1;
            e_rsp_rdata = q[0].data;
        end
        e_busy = (|req_valid) || (q.size() > 0);
    endfunction

    task automatic settle();
        @(negedge clk);
        eval_model();
    endtask

    // Clock edge: advance model with the beat evaluated at the last settle.
    task automatic advance();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            if (q.size() > 0 && q[0].due == cyc) begin m_last = q[0].data; void'(q.pop_front()); end
            if (e_acc) begin
                if (e_we) m_mem[e_addr] = e_wdata;
                else      q.push_back('{cyc + 2, e_gnt, m_mem[e_addr]});
                if (m_owner < 0) begin
                    if (LOCK && !req_last[e_gnt]) begin m_owner = e_gnt; m_beats = 1; end
                    else m_rr = (e_gnt + 1) % N;
                end else begin
                    m_beats++;
                    if (req_last[e_gnt] || m_beats == MB) begin m_owner = -1; m_rr = (e_gnt + 1) % N; end
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(int k, bit v, bit we, bit last, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[k] = v; req_we[k] = we; req_last[k] = last;
        req_addr[k*AW +: AW] = a; req_wdata[k*DW +: DW] = d;
    endtask

    task automatic idle(int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) begin settle(); advance(); end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        settle(); advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 3'b111; req_we = 3'b000; req_last = 3'b111;
        settle();
        n_cmp += 4;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        if (sram_en !== 1'b0)     begin n_err++; $display("FAIL reset_en got=%b exp=0", sram_en); end
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid); end
        if (rsp_rdata !== '0)     begin n_err++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        advance();
        rst = 1'b1; req_valid = '0;
        settle();
        n_cmp += 4;
        if (sram_en !== 1'b0)     begin n_err++; $display("FAIL idle_en got=%b exp=0", sram_en); end
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL idle_rsp_valid got=%b exp=000", rsp_valid); end
        if (busy !== 1'b0)        begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL idle_ready got=%b exp=000", req_ready); end
        advance();
    endtask

    task automatic test_write_read();
        set_req(1, 1, 1, 1, 12'h010, 32'hDEADBEEF);
        settle();
        n_cmp += 3;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL wr_ready got=%b exp=010", req_ready); end
        if ({sram_en, sram_we} !== 2'b11) begin n_err++; $display("FAIL wr_en_we got=%b exp=11", {sram_en, sram_we}); end
        if (sram_wdata !== 32'hDEADBEEF || sram_addr !== 12'h010) begin
            n_err++; $display("FAIL wr_port got=%h@%h exp=deadbeef@010", sram_wdata, sram_addr);
        end
        advance();
        set_req(1, 1, 0, 1, 12'h010, 32'h0);
        settle();
        n_cmp += 1;
        if ({sram_en, sram_we, sram_addr} !== {2'b10, 12'h010}) begin
            n_err++; $display("FAIL rd_port got=%b%b@%h exp=10@010", sram_en, sram_we, sram_addr);
        end
        advance();
        req_valid = '0;
        settle();
        n_cmp += 1;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL rd_early got=%b exp=000", rsp_valid); end
        advance();
        settle();
        n_cmp += 2;
        if (rsp_valid !== 3'b010) begin n_err++; $display("FAIL rd_rsp_valid got=%b exp=010", rsp_valid); end
        if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", rsp_rdata); end
        advance();
        idle(2);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_gnt, exp_rsp;
        req_valid = '0;
        for (int a = 1; a <= 3; a++) begin
            set_req(0, 1, 1, 1, AW'(a), 32'hA0000000 | a);
            settle(); advance();
        end
        for (int k = 0; k < N; k++) set_req(k, 1, 0, 1, AW'(k + 1), '0);
        do_reset();
        for (int k = 0; k < 9; k++) begin
            settle();
            exp_gnt = 3'b001 << (k % 3);
            n_cmp += 2;
            if (req_ready !== exp_gnt) begin n_err++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_gnt); end
            if (sram_addr !== AW'(k % 3 + 1)) begin n_err++; $display("FAIL rr_addr k=%0d got=%h exp=%0d", k, sram_addr, k % 3 + 1); end
            if (k >= 2) begin
                exp_rsp = 3'b001 << ((k - 2) % 3);
                n_cmp += 2;
                if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL rr_rsp k=%0d got=%b exp=%b", k, rsp_valid, exp_rsp); end
                if (rsp_rdata !== (32'hA0000000 | ((k - 2) % 3 + 1))) begin
                    n_err++; $display("FAIL rr_rdata k=%0d got=%h", k, rsp_rdata);
                end
            end
            advance();
        end
        idle(3);
    endtask

    task automatic test_reset_midflight();
        req_valid = '0;
        set_req(2, 1, 0, 1, 12'h002, '0);
        settle();
        n_cmp += 1;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL mf_grant got=%b exp=100", req_ready); end
        advance();
        rst = 1'b0; model_reset();
        settle();
        n_cmp += 2;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL mf_ready_in_reset got=%b exp=000", req_ready); end
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL mf_rsp_in_reset got=%b exp=000", rsp_valid); end
        advance();
        rst = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1, 0, 1, 12'h005, '0);
        settle();
        n_cmp += 2;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL mf_first_grant got=%b exp=001", req_ready); end
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL mf_stale_rsp got=%b exp=000", rsp_valid); end
        advance();
        req_valid = '0;
        settle();
        n_cmp += 1;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL mf_stale_rsp2 got=%b exp=000", rsp_valid); end
        advance();
        idle(3);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                set_req(k, ($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
                        AW'($urandom % 16), $urandom);
            settle();
            n_cmp += 8;
            if (req_ready !== e_ready)     begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
            if (sram_en !== e_en)          begin n_err++; $display("FAIL rand_en cyc=%0d got=%b exp=%b", cyc, sram_en, e_en); end
            if (sram_we !== e_we)          begin n_err++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", cyc, sram_we, e_we); end
            if (sram_addr !== e_addr)      begin n_err++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, sram_addr, e_addr); end
            if (sram_wdata !== e_wdata)    begin n_err++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, sram_wdata, e_wdata); end
            if (rsp_valid !== e_rsp_valid) begin n_err++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp_valid); end
            if (rsp_rdata !== e_rsp_rdata) begin n_err++; $display("FAIL rand_rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e_rsp_rdata); end
            if (busy !== e_busy)           begin n_err++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
            advance();
        end
        idle(3);
    endtask

`ifdef SRAM_ARB_BURST_LOCK_EN
    task automatic test_burst_lock();
        // Beat pattern for requester 2: beat, beat, gap, beat, last beat.
        bit v2 [5] = '{1, 1, 0, 1, 1};
        bit l2 [5] = '{0, 0, 0, 0, 1};
        req_valid = '0;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            set_req(2, v2[s], 1, l2[s], AW'(12'h020 + s), 32'h0);
            set_req(0, s > 0, 0, 1, 12'h001, '0);
            settle();
            n_cmp += 2;
            if (req_ready !== 3'b100) begin n_err++; $display("FAIL bl_ready s=%0d got=%b exp=100", s, req_ready); end
            if (sram_en !== v2[s]) begin n_err++; $display("FAIL bl_en s=%0d got=%b exp=%b", s, sram_en, v2[s]); end
            advance();
        end
        req_valid[2] = 1'b0;
        settle();
        n_cmp += 1;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL bl_release got=%b exp=001", req_ready); end
        advance();
        idle(3);
    endtask

    task automatic test_burst_max();
        req_valid = '0;
        do_reset();
        for (int b = 0; b <= MB; b++) begin
            set_req(2, 1, 1, 0, AW'(12'h040 + b), 32'h0);
            set_req(0, b > 0, 0, 1, 12'h001, '0);
            settle();
            n_cmp += 1;
            if (b < MB && req_ready !== 3'b100) begin n_err++; $display("FAIL bm_ready b=%0d got=%b exp=100", b, req_ready); end
            if (b == MB && req_ready !== 3'b001) begin n_err++; $display("FAIL bm_release got=%b exp=001", req_ready); end
            advance();
        end
        idle(3);
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b0; req_valid = '0; req_we = '0; req_last = '1;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_reset_midflight();
        test_random();
`ifdef SRAM_ARB_BURST_LOCK_EN
        test_burst_lock();
        test_burst_max();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
